// File: rtl/alu_pwr_ctrl_if.sv
// Signal bundle between the ALU power controller (slave) and the issuing /
// power-management logic plus the gated ALU (master side).
interface alu_pwr_ctrl_if;
  // start handshake: start_in is a one-cycle valid strobe, ready is the accept
  // qualifier, start_out = start_in && ready; a strobe seen with ready=0 is lost.
  logic       sleep_req;
  logic       wake_req;
  logic       alu_busy;
  logic       start_in;
  logic       start_out;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       ready;
  logic       sleep_err;
  logic [2:0] pwr_state;

  modport master (
    output sleep_req, wake_req, alu_busy, start_in,
    input  start_out, alu_pwr_en, iso_en, ready, sleep_err, pwr_state
  );

  modport slave (
    input  sleep_req, wake_req, alu_busy, start_in,
    output start_out, alu_pwr_en, iso_en, ready, sleep_err, pwr_state
  );
endinterface

// File: rtl/alu_pwr_ctrl.sv
// Power sequencer for the gated ALU: drains work, isolates, removes power,
// and restores power before releasing isolation.
module alu_pwr_ctrl #(
  parameter int unsigned ISO_CYC  = 2,
  parameter int unsigned PWR_CYC  = 4,
  parameter int unsigned DRAIN_TO = 8,
  parameter bit          BOOT_ON  = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_pwr_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ON    = 3'd0,
    ST_DRAIN = 3'd1,
    ST_ISO   = 3'd2,
    ST_OFF   = 3'd3,
    ST_PWRUP = 3'd4
  } state_t;

  localparam state_t           BOOT_ST     = BOOT_ON ? ST_ON : ST_OFF;
  localparam logic [CNT_W-1:0] ISO_LOAD    = CNT_W'(ISO_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LOAD    = CNT_W'(PWR_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TO - 1);
  localparam bit               DRAIN_TO_EN = (DRAIN_TO != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             block_q, block_d;
  logic             err_q, err_d;
  logic             pwr_en_q, iso_q, ready_q;

  // {pwr_en, iso_en, ready} for a given state
  function automatic logic [2:0] decode(input state_t s);
    case (s)
      ST_ON:    decode = 3'b101;
      ST_DRAIN: decode = 3'b100;
      ST_ISO:   decode = 3'b110;
      ST_OFF:   decode = 3'b010;
      ST_PWRUP: decode = 3'b110;
      default:  decode = 3'b010;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_ON: begin
        cnt_d = '0;
        if (bus.sleep_req && !bus.wake_req && !block_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // cnt counts cycles already spent in DRAIN
        cnt_d = cnt_q + 1'b1;
        if (bus.wake_req) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (!bus.alu_busy) begin
          state_d = ST_ISO;
          cnt_d   = ISO_LOAD;
        end else if (DRAIN_TO_EN && (cnt_q == DRAIN_LAST)) begin
          state_d = ST_ON;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_ISO: begin
        if (bus.wake_req) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OFF: begin
        if (bus.wake_req) begin
          state_d = ST_PWRUP;
          cnt_d   = PWR_LOAD;
        end
      end
      ST_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = BOOT_ST;
        cnt_d   = '0;
      end
    endcase

    // a timed-out sleep stays blocked until the requester lets go of sleep_req
    block_d = block_q;
    if (err_d)               block_d = 1'b1;
    else if (!bus.sleep_req) block_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                       <= BOOT_ST;
      cnt_q                         <= '0;
      block_q                       <= 1'b0;
      err_q                         <= 1'b0;
      {pwr_en_q, iso_q, ready_q}    <= decode(BOOT_ST);
    end else begin
      state_q                       <= state_d;
      cnt_q                         <= cnt_d;
      block_q                       <= block_d;
      err_q                         <= err_d;
      {pwr_en_q, iso_q, ready_q}    <= decode(state_d);
    end
  end

  assign bus.alu_pwr_en = pwr_en_q;
  assign bus.iso_en     = iso_q;
  assign bus.ready      = ready_q;
  assign bus.sleep_err  = err_q;
  assign bus.pwr_state  = state_q;
  assign bus.start_out  = bus.start_in & ready_q;

endmodule
